// File: rtl/mmcm_drp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_drp_ctrl_if
// Brief    : Request, table-lookup, DRP and MMCM-control bundle of the
//            MMCM reconfiguration controller.
// Revision : 1.0
// ============================================================================
interface mmcm_drp_ctrl_if;
    logic        cfg_req;
    logic        cfg_mode;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        tbl_mode;
    logic [4:0]  tbl_idx;
    logic [6:0]  tbl_addr;
    logic [15:0] tbl_mask;
    logic [15:0] tbl_data;
    logic [6:0]  drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_den;
    logic        drp_dwe;
    logic        drp_drdy;
    logic        mmcm_rst;
    logic        mmcm_locked;
    logic        clk_locked;

    modport master (
        input  cfg_req, cfg_mode, tbl_addr, tbl_mask, tbl_data,
               drp_do, drp_drdy, mmcm_locked,
        output cfg_busy, cfg_done, cfg_err, tbl_mode, tbl_idx,
               drp_addr, drp_di, drp_den, drp_dwe, mmcm_rst, clk_locked
    );

    modport slave (
        output cfg_req, cfg_mode, tbl_addr, tbl_mask, tbl_data,
               drp_do, drp_drdy, mmcm_locked,
        input  cfg_busy, cfg_done, cfg_err, tbl_mode, tbl_idx,
               drp_addr, drp_di, drp_den, drp_dwe, mmcm_rst, clk_locked
    );
endinterface
`default_nettype wire

// File: rtl/mmcm_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mmcm_drp_ctrl
// Brief    : Read-modify-write MMCM reconfiguration over DRP from an external
//            mode/index table, then waits for lock.
// Revision : 1.0
// ============================================================================
module mmcm_drp_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  wire logic     clk_100m,
    input  wire logic     rst_n,
    mmcm_drp_ctrl_if.master bus
);

    localparam int c_CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_DRDY_LAST = c_CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [4:0]         c_IDX_LAST  = 5'(NUM_REGS - 1);

    localparam logic [3:0] c_S_IDLE      = 4'd0;
    localparam logic [3:0] c_S_RST       = 4'd1;
    localparam logic [3:0] c_S_RD        = 4'd2;
    localparam logic [3:0] c_S_RD_WAIT   = 4'd3;
    localparam logic [3:0] c_S_WR        = 4'd4;
    localparam logic [3:0] c_S_WR_WAIT   = 4'd5;
    localparam logic [3:0] c_S_LOCK_WAIT = 4'd6;
    localparam logic [3:0] c_S_DONE      = 4'd7;
    localparam logic [3:0] c_S_ERR       = 4'd8;

    logic [3:0]         r_state;
    logic [3:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_lock_meta;
    logic               r_lock_sync;
    logic [4:0]         r_tbl_idx;
    logic               r_tbl_mode;
    logic [15:0]        r_rd_val;
    logic               r_cfg_err;

    logic               w_busy;
    logic               w_done;
    logic               w_den;
    logic               w_dwe;
    logic [6:0]         w_addr;
    logic [15:0]        w_di;
    logic               w_mmcm_rst;
    logic               w_in_wait;

    // LOCKED comes straight from the MMCM with no relation to clk_100m.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= bus.mmcm_locked;
            r_lock_sync <= r_lock_meta;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // drdy is only looked at in the wait states, so a response coincident
    // with the den pulse (or arriving while idle) can never advance the FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:      if (bus.cfg_req) w_state_nxt = c_S_RST;
            c_S_RST:       w_state_nxt = c_S_RD;
            c_S_RD:        w_state_nxt = c_S_RD_WAIT;
            c_S_RD_WAIT: begin
                if (bus.drp_drdy)               w_state_nxt = c_S_WR;
                else if (r_cnt == c_DRDY_LAST)  w_state_nxt = c_S_ERR;
            end
            c_S_WR:        w_state_nxt = c_S_WR_WAIT;
            c_S_WR_WAIT: begin
                if (bus.drp_drdy)
                    w_state_nxt = (r_tbl_idx == c_IDX_LAST) ? c_S_LOCK_WAIT : c_S_RD;
                else if (r_cnt == c_DRDY_LAST)
                    w_state_nxt = c_S_ERR;
            end
            c_S_LOCK_WAIT: begin
                if (r_lock_sync)                w_state_nxt = c_S_DONE;
                else if (r_cnt == c_LOCK_LAST)  w_state_nxt = c_S_ERR;
            end
            c_S_DONE:      w_state_nxt = c_S_IDLE;
            c_S_ERR:       w_state_nxt = c_S_IDLE;
            default:       w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy     = (r_state != c_S_IDLE);
        w_done     = (r_state == c_S_DONE);
        w_den      = 1'b0;
        w_dwe      = 1'b0;
        w_addr     = 7'd0;
        w_di       = 16'd0;
        w_mmcm_rst = 1'b0;
        w_in_wait  = 1'b0;
        case (r_state)
            c_S_RST: begin
                w_mmcm_rst = 1'b1;
            end
            c_S_RD: begin
                w_mmcm_rst = 1'b1;
                w_den      = 1'b1;
                w_addr     = bus.tbl_addr;
            end
            c_S_RD_WAIT: begin
                w_mmcm_rst = 1'b1;
                w_in_wait  = 1'b1;
            end
            c_S_WR: begin
                w_mmcm_rst = 1'b1;
                w_den      = 1'b1;
                w_dwe      = 1'b1;
                w_addr     = bus.tbl_addr;
                w_di       = (r_rd_val & bus.tbl_mask) | (bus.tbl_data & ~bus.tbl_mask);
            end
            c_S_WR_WAIT: begin
                w_mmcm_rst = 1'b1;
                w_in_wait  = 1'b1;
            end
            c_S_LOCK_WAIT: begin
                w_in_wait  = 1'b1;
            end
            default: begin
                w_mmcm_rst = 1'b0;
            end
        endcase
    end

    // One counter serves all wait states; any state change restarts it.
    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= '0;
        end else if (w_in_wait) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_tbl_idx  <= 5'd0;
            r_tbl_mode <= 1'b0;
            r_rd_val   <= 16'd0;
            r_cfg_err  <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE && bus.cfg_req) begin
                r_tbl_mode <= bus.cfg_mode;
                r_tbl_idx  <= 5'd0;
                r_cfg_err  <= 1'b0;
            end
            if (r_state == c_S_RD_WAIT && bus.drp_drdy) begin
                r_rd_val <= bus.drp_do;
            end
            if (r_state == c_S_WR_WAIT && bus.drp_drdy && r_tbl_idx != c_IDX_LAST) begin
                r_tbl_idx <= r_tbl_idx + 5'd1;
            end
            // Set on entry so the flag is already visible while in ERR.
            if (w_state_nxt == c_S_ERR) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign bus.cfg_busy   = w_busy;
    assign bus.cfg_done   = w_done;
    assign bus.cfg_err    = r_cfg_err;
    assign bus.tbl_mode   = r_tbl_mode;
    assign bus.tbl_idx    = r_tbl_idx;
    assign bus.drp_den    = w_den;
    assign bus.drp_dwe    = w_dwe;
    assign bus.drp_addr   = w_addr;
    assign bus.drp_di     = w_di;
    assign bus.mmcm_rst   = w_mmcm_rst;
    assign bus.clk_locked = r_lock_sync & ~w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmcm_drp_ctrl
// Brief    : Scoreboard bench with a DRP register model and an MMCM lock model.
// Revision : 1.0
// ============================================================================
module tb_mmcm_drp_ctrl;

    localparam int NR = 2;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } acc_t;

    logic clk;
    logic rst_n;
    mmcm_drp_ctrl_if bus();

    mmcm_drp_ctrl #(
        .NUM_REGS     (NR),
        .DRDY_TIMEOUT (64),
        .LOCK_TIMEOUT (100)
    ) u_dut (
        .clk_100m (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_rd     = 0;
    int          n_wr     = 0;
    logic [15:0] mem    [128];
    logic [15:0] shadow [128];
    acc_t        sb[$];
    bit          drdy_en = 1'b1;
    bit          spur_en = 1'b0;
    bit          lock_en = 1'b1;
    int          rcnt    = 0;
    logic [6:0]  raddr   = 7'd0;
    int          lcnt    = 0;

    function automatic logic [6:0] addr_of(input logic m, input logic [4:0] i);
        return m ? (7'h40 + 7'(i) * 7'd3) : (7'h08 + 7'(i) * 7'd5);
    endfunction

    function automatic logic [15:0] mask_of(input logic [4:0] i);
        case (i)
            5'd0:    return 16'hFF00;
            5'd1:    return 16'h0F0F;
            default: return 16'hF0F0;
        endcase
    endfunction

    function automatic logic [15:0] data_of(input logic [4:0] i);
        case (i)
            5'd0:    return 16'h1234;
            5'd1:    return 16'hABCD;
            default: return 16'h5555;
        endcase
    endfunction

    assign bus.tbl_addr = addr_of(bus.tbl_mode, bus.tbl_idx);
    assign bus.tbl_mask = mask_of(bus.tbl_idx);
    assign bus.tbl_data = data_of(bus.tbl_idx);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // DRP register model: drdy three cycles after den, optional stray drdy in
    // the den cycle itself carrying a poison value.
    initial begin
        bus.drp_drdy = 1'b0;
        bus.drp_do   = 16'd0;
        forever begin
            @(negedge clk);
            bus.drp_drdy = 1'b0;
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    bus.drp_drdy = 1'b1;
                    bus.drp_do   = mem[raddr];
                end
            end
            if (rst_n && bus.drp_den) begin
                if (bus.drp_dwe) mem[bus.drp_addr] = bus.drp_di;
                if (drdy_en) begin
                    rcnt  = 3;
                    raddr = bus.drp_addr;
                end
                if (spur_en) begin
                    bus.drp_drdy = 1'b1;
                    bus.drp_do   = 16'hDEAD;
                end
            end
        end
    end

    initial begin
        bus.mmcm_locked = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mmcm_rst) begin
                bus.mmcm_locked = 1'b0;
                lcnt = 0;
            end else if (lock_en && !bus.mmcm_locked) begin
                lcnt++;
                if (lcnt >= 10) bus.mmcm_locked = 1'b1;
            end
        end
    end

    // Scoreboard consumer: every den pulse must match the next expected access.
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.drp_den) begin
                    if (sb.size() == 0) begin
                        chk("den_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("drp_dwe", 32'(bus.drp_dwe), 32'(e.we));
                        chk("drp_addr", 32'(bus.drp_addr), 32'(e.addr));
                        if (e.we) chk("drp_di", 32'(bus.drp_di), 32'(e.di));
                    end
                    if (bus.drp_dwe) n_wr++;
                    else             n_rd++;
                end else begin
                    chk("idle_addr", 32'(bus.drp_addr), 32'd0);
                    chk("idle_di", 32'(bus.drp_di), 32'd0);
                end
            end
        end
    end

    task automatic start_cfg(input logic m, input int n_ent);
        logic [6:0]  a;
        logic [15:0] wv;
        int          k;
        acc_t        e;
        k = 0;
        for (int i = 0; i < 128; i++) shadow[i] = mem[i];
        for (int i = 0; i < NR; i++) begin
            a  = addr_of(m, 5'(i));
            wv = (shadow[a] & mask_of(5'(i))) | (data_of(5'(i)) & ~mask_of(5'(i)));
            if (k < n_ent) begin
                e = '{we: 1'b0, addr: a, di: 16'd0};
                sb.push_back(e);
                k++;
            end
            if (k < n_ent) begin
                e = '{we: 1'b1, addr: a, di: wv};
                sb.push_back(e);
                k++;
            end
            shadow[a] = wv;
        end
        @(negedge clk);
        bus.cfg_mode = m;
        bus.cfg_req  = 1'b1;
        @(negedge clk);
        bus.cfg_req  = 1'b0;
        chk("busy_after_req", 32'(bus.cfg_busy), 32'd1);
        chk("tbl_mode", 32'(bus.tbl_mode), 32'(m));
        chk("err_cleared", 32'(bus.cfg_err), 32'd0);
        chk("clk_locked_busy", 32'(bus.clk_locked), 32'd0);
    endtask

    task automatic wait_idle(input bit noisy, output int dones);
        int cyc;
        dones = 0;
        cyc   = 0;
        while (bus.cfg_busy && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (bus.cfg_done) dones++;
            bus.cfg_req = (noisy && bus.mmcm_rst) ? 1'($urandom % 2) : 1'b0;
        end
        bus.cfg_req = 1'b0;
        chk("cfg_finished", 32'(bus.cfg_busy), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 32'(bus.cfg_busy), 32'd0);
        chk({pfx, "_done"}, 32'(bus.cfg_done), 32'd0);
        chk({pfx, "_err"}, 32'(bus.cfg_err), 32'd0);
        chk({pfx, "_den"}, 32'(bus.drp_den), 32'd0);
        chk({pfx, "_dwe"}, 32'(bus.drp_dwe), 32'd0);
        chk({pfx, "_addr"}, 32'(bus.drp_addr), 32'd0);
        chk({pfx, "_di"}, 32'(bus.drp_di), 32'd0);
        chk({pfx, "_mmcm_rst"}, 32'(bus.mmcm_rst), 32'd0);
        chk({pfx, "_idx"}, 32'(bus.tbl_idx), 32'd0);
        chk({pfx, "_mode"}, 32'(bus.tbl_mode), 32'd0);
        chk({pfx, "_clk_locked"}, 32'(bus.clk_locked), 32'd0);
    endtask

    initial begin
        int d;
        int w;
        int cnt;
        int rd0;
        int wr0;
        rst_n        = 1'b0;
        bus.cfg_req  = 1'b0;
        bus.cfg_mode = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
        mem[8] = 16'hA5A5;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("locked_idle", 32'(bus.clk_locked), 32'd1);

        // Mode 0 sequence with the A5A5/FF00/1234 merge on entry 0.
        rd0 = n_rd;
        wr0 = n_wr;
        start_cfg(1'b0, 2 * NR);
        wait_idle(1'b0, d);
        chk("m0_done_pulses", 32'(d), 32'd1);
        chk("m0_err", 32'(bus.cfg_err), 32'd0);
        chk("m0_reads", 32'(n_rd - rd0), 32'd2);
        chk("m0_writes", 32'(n_wr - wr0), 32'd2);
        chk("m0_sb_empty", 32'(sb.size()), 32'd0);
        chk("m0_merge_a534", 32'(mem[8]), 32'h0000A534);
        chk("m0_clk_locked", 32'(bus.clk_locked), 32'd1);

        // Mode 1 with cfg_req chatter while busy and drdy alongside den.
        rd0     = n_rd;
        wr0     = n_wr;
        spur_en = 1'b1;
        start_cfg(1'b1, 2 * NR);
        wait_idle(1'b1, d);
        spur_en = 1'b0;
        chk("m1_done_pulses", 32'(d), 32'd1);
        chk("m1_err", 32'(bus.cfg_err), 32'd0);
        chk("m1_reads", 32'(n_rd - rd0), 32'd2);
        chk("m1_writes", 32'(n_wr - wr0), 32'd2);
        chk("m1_sb_empty", 32'(sb.size()), 32'd0);
        repeat (10) @(negedge clk);
        chk("m1_no_restart", 32'(bus.cfg_busy), 32'd0);

        // No drdy at all: the first read must time out.
        drdy_en = 1'b0;
        start_cfg(1'b0, 1);
        w = 0;
        while (!bus.drp_den && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("to_rd_pulse_seen", 32'(bus.drp_den), 32'd1);
        cnt = 0;
        while (!bus.cfg_err && cnt < 200) begin
            @(negedge clk);
            if (!bus.cfg_err) cnt++;
        end
        chk("drdy_timeout_cycles", 32'(cnt), 32'd64);
        chk("to_mmcm_rst", 32'(bus.mmcm_rst), 32'd0);
        chk("to_no_done", 32'(bus.cfg_done), 32'd0);
        @(negedge clk);
        chk("to_idle", 32'(bus.cfg_busy), 32'd0);
        chk("to_err_sticky", 32'(bus.cfg_err), 32'd1);
        chk("to_sb_empty", 32'(sb.size()), 32'd0);
        drdy_en = 1'b1;
        repeat (20) @(negedge clk);

        // Lock never returns, then a good run clears the sticky error.
        lock_en = 1'b0;
        start_cfg(1'b0, 2 * NR);
        w = 0;
        while (bus.mmcm_rst && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("lock_wait_reached", 32'(bus.mmcm_rst), 32'd0);
        cnt = 0;
        while (!bus.cfg_err && cnt < 500) begin
            if (bus.cfg_busy && !bus.mmcm_rst) cnt++;
            @(negedge clk);
        end
        chk("lock_timeout_cycles", 32'(cnt), 32'd100);
        chk("lt_err", 32'(bus.cfg_err), 32'd1);
        chk("lt_no_done", 32'(bus.cfg_done), 32'd0);
        chk("lt_sb_empty", 32'(sb.size()), 32'd0);
        lock_en = 1'b1;
        repeat (20) @(negedge clk);
        start_cfg(1'b1, 2 * NR);
        wait_idle(1'b0, d);
        chk("rec_done_pulses", 32'(d), 32'd1);
        chk("rec_err_clear", 32'(bus.cfg_err), 32'd0);

        // Reset asserted while waiting for the first write's drdy.
        start_cfg(1'b1, 2 * NR);
        w = 0;
        while (!(bus.drp_den && bus.drp_dwe) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("rst_wr_seen", 32'(bus.drp_dwe), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.drp_den) cnt++;
        end
        chk("post_rst_no_den", 32'(cnt), 32'd0);
        chk("post_rst_idle", 32'(bus.cfg_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmcm_drp_ctrl.md
MMCM_DRP_CTRL -- requirements
Module: mmcm_drp_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8, meaning the number of DRP register entries written per reconfiguration (1-32).
REQ-002 SHALL have parameter DRDY_TIMEOUT, default 64, meaning the maximum clk_100m cycles to wait for drp_drdy after a DRP access.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535, meaning the maximum clk_100m cycles to wait for lock after the MMCM reset is released.
REQ-004 SHALL provide ports:
- clk_100m  in  1  sole clock, 100 MHz MMCM input clock
- rst_n  in  1  asynchronous active-low reset
- cfg_req  in  1  start reconfiguration (level sampled in IDLE)
- cfg_mode  in  1  target mode (0 = 640x480p60, 1 = alternate mode), captured at start
- cfg_busy  out  1  reconfiguration in progress
- cfg_done  out  1  one-cycle pulse on successful completion
- cfg_err  out  1  sticky error flag, cleared at the next accepted cfg_req
- tbl_mode  out  1  captured mode presented to the external table
- tbl_idx  out  5  table entry index
- tbl_addr  in  7  DRP address for (tbl_mode, tbl_idx); combinational lookup
- tbl_mask  in  16  bits to KEEP from the read value (1 = keep)
- tbl_data  in  16  new bit values (used where mask = 0)
- drp_addr  out  7  DRP address
- drp_di  out  16  DRP write data
- drp_do  in  16  DRP read data
- drp_den  out  1  DRP enable, single-cycle pulse
- drp_dwe  out  1  DRP write enable, qualified by drp_den
- drp_drdy  in  1  DRP ready
- mmcm_rst  out  1  MMCM reset
- mmcm_locked  in  1  raw, asynchronous MMCM LOCKED
- clk_locked  out  1  synchronized lock, valid only when not busy

Function
REQ-005 SHALL synchronize mmcm_locked through two clk_100m flops; all internal lock decisions SHALL use the second flop.
REQ-006 SHALL implement states IDLE, RST, RD, RD_WAIT, WR, WR_WAIT, LOCK_WAIT, DONE, ERR.
REQ-007 In IDLE with cfg_req=1: SHALL capture cfg_mode into tbl_mode, clear cfg_err, set tbl_idx=0 and go to RST; cfg_req while not in IDLE SHALL be ignored.
REQ-008 RST: SHALL assert mmcm_rst (held until LOCK_WAIT entry) and go to RD the next cycle.
REQ-009 RD: SHALL pulse drp_den=1, drp_dwe=0, drp_addr=tbl_addr for exactly one cycle, then go to RD_WAIT.
REQ-010 RD_WAIT: on drp_drdy SHALL register drp_do and go to WR.
REQ-011 WR: SHALL pulse drp_den=1, drp_dwe=1, drp_addr=tbl_addr, drp_di=(rd_val & tbl_mask) | (tbl_data & ~tbl_mask) for one cycle, then go to WR_WAIT.
REQ-012 WR_WAIT: on drp_drdy, if tbl_idx = NUM_REGS-1 SHALL go to LOCK_WAIT, else SHALL increment tbl_idx and go to RD.
REQ-013 drp_drdy arriving in the same cycle as drp_den SHALL be ignored; drp_drdy outside RD_WAIT/WR_WAIT SHALL be ignored.
REQ-014 Each wait state SHALL use one shared cycle counter cleared on state entry; RD_WAIT/WR_WAIT reaching DRDY_TIMEOUT cycles without drdy SHALL go to ERR.
REQ-015 LOCK_WAIT: mmcm_rst=0; synced lock=1 SHALL go to DONE; LOCK_TIMEOUT cycles without lock SHALL go to ERR.
REQ-016 DONE: SHALL pulse cfg_done for one cycle and return to IDLE.
REQ-017 ERR: SHALL set cfg_err=1, deassert mmcm_rst and return to IDLE the next cycle.
REQ-018 cfg_busy SHALL be 1 in every state except IDLE.
REQ-019 clk_locked SHALL equal synced lock AND NOT cfg_busy.
REQ-020 drp_addr/drp_di SHALL be 0 whenever drp_den=0.

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE, tbl_idx=0, tbl_mode=0, cfg_busy=0, cfg_done=0, cfg_err=0, drp_den=0, drp_dwe=0, drp_addr=0, drp_di=0, mmcm_rst=0, sync flops=0, counter=0.
REQ-022 Reset asserted mid-sequence SHALL abandon the sequence with no further DRP access; a DRP access in flight SHALL be abandoned.

Verification
REQ-023 NUM_REGS=2, DRP model drdy 3 cycles after den, lock 10 cycles after mmcm_rst falls -> exactly 2 reads and 2 writes, in order RD/WR idx0, RD/WR idx1; one cfg_done pulse; cfg_err=0.
REQ-024 Read value 0xA5A5, tbl_mask 0xFF00, tbl_data 0x1234 -> drp_di=0xA534.
REQ-025 DRP model never asserts drdy, DRDY_TIMEOUT=64 -> ERR 64 cycles after the first read pulse; cfg_err=1; mmcm_rst=0; no cfg_done.
REQ-026 Lock never returns, LOCK_TIMEOUT=100 -> cfg_err=1 after 100 LOCK_WAIT cycles; a subsequent successful cfg_req clears cfg_err.
REQ-027 cfg_req toggled during busy and drdy coincident with den -> request ignored; drdy ignored; DRP access count unchanged.
REQ-028 rst_n low during WR_WAIT -> all outputs at reset values immediately; no drp_den after release until a new cfg_req.
